// File: rtl/wishbone_arbiter_pkg.sv
// Shared types and constants for the two-primary Wishbone arbiter.
package wishbone_arbiter_pkg;

  localparam int unsigned ARB_PORTS = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/wishbone_if.sv
// Wishbone bus bundle; every field width used by the arbiter comes from here.
interface wishbone_if #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned TgdWidth  = 4
);
  localparam int unsigned SelWidth = DataWidth / 8;

  logic                 cyc;
  logic                 stb;
  logic                 we;
  logic [TgdWidth-1:0]  tgd;
  logic [SelWidth-1:0]  sel;
  logic [AddrWidth-1:0] addr;
  logic [DataWidth-1:0] dat_w;
  logic [DataWidth-1:0] dat_r;
  logic                 ack;

  modport primary (
    output cyc, stb, we, tgd, sel, addr, dat_w,
    input  ack, dat_r
  );

  modport secondary (
    input  cyc, stb, we, tgd, sel, addr, dat_w,
    output ack, dat_r
  );
endinterface

// File: rtl/wishbone_arbiter.sv
// Two-primary, one-secondary Wishbone arbiter holding each grant for a whole cyc,
// with fixed-priority or round-robin tie-breaking and an optional no-ack watchdog.
module wishbone_arbiter
  import wishbone_arbiter_pkg::*;
#(
  parameter bit          ROUND_ROBIN    = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic                 clock,
  input  logic                 reset,
  wishbone_if.secondary        wish_s_p0,
  wishbone_if.secondary        wish_s_p1,
  wishbone_if.primary          wish_p,
  output logic                 timeout,
  output logic [ARB_PORTS-1:0] grant
);

  localparam int unsigned CntWidth =
      (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CntWidth-1:0] CntMax = CntWidth'(TIMEOUT_CYCLES);

  arb_state_t            state_q;
  logic                  last_q;
  logic [ARB_PORTS-1:0]  grant_q;
  logic [CntWidth-1:0]   cnt_q, cnt_d;

  logic req0, req1;
  logic sel0, sel1;
  logic wd_hit;

  assign req0  = wish_s_p0.cyc & wish_s_p0.stb;
  assign req1  = wish_s_p1.cyc & wish_s_p1.stb;
  assign sel0  = (state_q == GRANT0);
  assign sel1  = (state_q == GRANT1);
  assign grant = grant_q;

  // Counter only reaches CntMax while granted; the hit forces stb low, which clears it.
  assign wd_hit = (TIMEOUT_CYCLES != 0) && (state_q != IDLE) && (cnt_q == CntMax);

  always_comb begin
    wish_p.cyc   = 1'b0;
    wish_p.stb   = 1'b0;
    wish_p.we    = 1'b0;
    wish_p.tgd   = '0;
    wish_p.sel   = '0;
    wish_p.addr  = '0;
    wish_p.dat_w = '0;
    if (sel0) begin
      wish_p.cyc   = wish_s_p0.cyc;
      wish_p.stb   = wish_s_p0.stb & ~wd_hit;
      wish_p.we    = wish_s_p0.we;
      wish_p.tgd   = wish_s_p0.tgd;
      wish_p.sel   = wish_s_p0.sel;
      wish_p.addr  = wish_s_p0.addr;
      wish_p.dat_w = wish_s_p0.dat_w;
    end else if (sel1) begin
      wish_p.cyc   = wish_s_p1.cyc;
      wish_p.stb   = wish_s_p1.stb & ~wd_hit;
      wish_p.we    = wish_s_p1.we;
      wish_p.tgd   = wish_s_p1.tgd;
      wish_p.sel   = wish_s_p1.sel;
      wish_p.addr  = wish_s_p1.addr;
      wish_p.dat_w = wish_s_p1.dat_w;
    end

    // A real ack in the hit cycle takes precedence over the synthetic one.
    timeout         = wd_hit & ~wish_p.ack;
    wish_s_p0.ack   = sel0 & (wish_p.ack | wd_hit);
    wish_s_p1.ack   = sel1 & (wish_p.ack | wd_hit);
    wish_s_p0.dat_r = (sel0 && !timeout) ? wish_p.dat_r : '0;
    wish_s_p1.dat_r = (sel1 && !timeout) ? wish_p.dat_r : '0;

    if (wish_p.stb && !wish_p.ack) begin
      cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + CntWidth'(1);
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      grant_q <= '0;
      cnt_q   <= '0;
    end else begin
      cnt_q <= cnt_d;
      unique case (state_q)
        IDLE: begin
          // On a tie, round-robin grants the port that was not served last.
          if (req0 && (!req1 || !ROUND_ROBIN || last_q)) begin
            state_q <= GRANT0;
            last_q  <= 1'b0;
            grant_q <= 2'b01;
          end else if (req1) begin
            state_q <= GRANT1;
            last_q  <= 1'b1;
            grant_q <= 2'b10;
          end
        end
        GRANT0: begin
          if (!wish_s_p0.cyc) begin
            state_q <= IDLE;
            grant_q <= '0;
          end
        end
        GRANT1: begin
          if (!wish_s_p1.cyc) begin
            state_q <= IDLE;
            grant_q <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wishbone_arbiter.sv
// Directed bench for wishbone_arbiter: a round-robin/watchdog instance and a
// fixed-priority instance share one stimulus; each table row selects which to check.
module tb_wishbone_arbiter;

  localparam logic [31:0] P0_ADDR = 32'h0000_0200;
  localparam logic [31:0] P1_ADDR = 32'h0000_0100;
  localparam logic [31:0] P0_WDAT = 32'h1111_1111;
  localparam logic [31:0] P1_WDAT = 32'h2222_2222;
  localparam logic [31:0] SEC_RD  = 32'hDEAD_BEEF;
  localparam int          OBS_W   = 144;

  typedef struct {
    bit       dut;   // 0: round-robin + watchdog, 1: fixed priority
    bit       chk;
    bit       rst;
    bit       r0;
    bit       r1;
    bit       ack;
    bit [1:0] g;
    bit       a0;
    bit       a1;
    bit       cyc;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, p0_req, p1_req, s_ack;
  logic       a_tmo, b_tmo;
  logic [1:0] a_grant, b_grant;
  int checks = 0;
  int failures = 0;
  vec_t tbl[$];

  wishbone_if a_p0 ();
  wishbone_if a_p1 ();
  wishbone_if a_s ();
  wishbone_if b_p0 ();
  wishbone_if b_p1 ();
  wishbone_if b_s ();

  assign a_p0.cyc = p0_req;  assign a_p0.stb = p0_req;  assign a_p0.we = 1'b1;
  assign a_p0.tgd = 4'h3;    assign a_p0.sel = 4'hF;    assign a_p0.addr = P0_ADDR;
  assign a_p0.dat_w = P0_WDAT;
  assign b_p0.cyc = p0_req;  assign b_p0.stb = p0_req;  assign b_p0.we = 1'b1;
  assign b_p0.tgd = 4'h3;    assign b_p0.sel = 4'hF;    assign b_p0.addr = P0_ADDR;
  assign b_p0.dat_w = P0_WDAT;
  assign a_p1.cyc = p1_req;  assign a_p1.stb = p1_req;  assign a_p1.we = 1'b0;
  assign a_p1.tgd = 4'hC;    assign a_p1.sel = 4'h3;    assign a_p1.addr = P1_ADDR;
  assign a_p1.dat_w = P1_WDAT;
  assign b_p1.cyc = p1_req;  assign b_p1.stb = p1_req;  assign b_p1.we = 1'b0;
  assign b_p1.tgd = 4'hC;    assign b_p1.sel = 4'h3;    assign b_p1.addr = P1_ADDR;
  assign b_p1.dat_w = P1_WDAT;
  assign a_s.ack = s_ack;    assign a_s.dat_r = SEC_RD;
  assign b_s.ack = s_ack;    assign b_s.dat_r = SEC_RD;

  wishbone_arbiter #(.ROUND_ROBIN(1'b1), .TIMEOUT_CYCLES(8)) dut_a (
    .clock(clk), .reset(rst), .wish_s_p0(a_p0), .wish_s_p1(a_p1), .wish_p(a_s),
    .timeout(a_tmo), .grant(a_grant)
  );

  wishbone_arbiter #(.ROUND_ROBIN(1'b0), .TIMEOUT_CYCLES(0)) dut_b (
    .clock(clk), .reset(rst), .wish_s_p0(b_p0), .wish_s_p1(b_p1), .wish_p(b_s),
    .timeout(b_tmo), .grant(b_grant)
  );

  logic [OBS_W-1:0] obs_a, obs_b;
  assign obs_a = {a_grant, a_s.cyc, a_s.stb, a_s.we, a_s.sel, a_s.tgd, a_p0.ack, a_p1.ack,
                  a_tmo, a_s.addr, a_s.dat_w, a_p0.dat_r, a_p1.dat_r};
  assign obs_b = {b_grant, b_s.cyc, b_s.stb, b_s.we, b_s.sel, b_s.tgd, b_p0.ack, b_p1.ack,
                  b_tmo, b_s.addr, b_s.dat_w, b_p0.dat_r, b_p1.dat_r};

  function automatic vec_t v(input bit dut, chk, rst_v, r0, r1, ack, input bit [1:0] g,
                             input bit a0, a1, cyc);
    vec_t t;
    t.dut = dut; t.chk = chk; t.rst = rst_v; t.r0 = r0; t.r1 = r1; t.ack = ack;
    t.g = g; t.a0 = a0; t.a1 = a1; t.cyc = cyc;
    return t;
  endfunction

  // Expected bus view derived from the expected owner: the owner's fields, else zeros.
  function automatic logic [OBS_W-1:0] expect_obs(input vec_t t);
    logic        g0, g1;
    logic [3:0]  sel, tgd;
    logic [31:0] addr, wdat;
    g0   = t.g[0];
    g1   = t.g[1];
    sel  = g0 ? 4'hF : (g1 ? 4'h3 : 4'h0);
    tgd  = g0 ? 4'h3 : (g1 ? 4'hC : 4'h0);
    addr = g0 ? P0_ADDR : (g1 ? P1_ADDR : 32'h0);
    wdat = g0 ? P0_WDAT : (g1 ? P1_WDAT : 32'h0);
    return {t.g, t.cyc, t.cyc, g0, sel, tgd, t.a0, t.a1, 1'b0, addr, wdat,
            (g0 ? SEC_RD : 32'h0), (g1 ? SEC_RD : 32'h0)};
  endfunction

  task automatic check(input string name, input logic [OBS_W-1:0] got, exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  initial begin
    rst = 1'b1; p0_req = 1'b0; p1_req = 1'b0; s_ack = 1'b0;

    // Single requester: p1 alone, secondary acks on its second granted cycle.
    tbl.push_back(v(0, 0, 1, 0, 0, 0, 2'b00, 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 1, 0, 2'b00, 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 1, 0, 2'b10, 0, 0, 1));
    tbl.push_back(v(0, 1, 0, 0, 1, 1, 2'b10, 0, 1, 1));
    tbl.push_back(v(0, 1, 0, 0, 0, 0, 2'b10, 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0));
    // Round-robin tie, 1-beat transfers: 01, release, idle, 10, release, idle, 01.
    tbl.push_back(v(0, 0, 1, 0, 0, 0, 2'b00, 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 1, 1, 0, 2'b00, 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 1, 1, 1, 2'b01, 1, 0, 1));
    tbl.push_back(v(0, 1, 0, 0, 1, 0, 2'b01, 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 1, 1, 0, 2'b00, 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 1, 1, 1, 2'b10, 0, 1, 1));
    tbl.push_back(v(0, 1, 0, 1, 0, 0, 2'b10, 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 1, 1, 0, 2'b00, 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 1, 1, 1, 2'b01, 1, 0, 1));
    // Fixed priority: p0 wins every tie until it stops requesting.
    tbl.push_back(v(1, 0, 1, 0, 0, 0, 2'b00, 0, 0, 0));
    tbl.push_back(v(1, 1, 0, 1, 1, 0, 2'b00, 0, 0, 0));
    tbl.push_back(v(1, 1, 0, 1, 1, 1, 2'b01, 1, 0, 1));
    tbl.push_back(v(1, 1, 0, 0, 1, 0, 2'b01, 0, 0, 0));
    tbl.push_back(v(1, 1, 0, 1, 1, 0, 2'b00, 0, 0, 0));
    tbl.push_back(v(1, 1, 0, 1, 1, 1, 2'b01, 1, 0, 1));
    tbl.push_back(v(1, 1, 0, 0, 1, 0, 2'b01, 0, 0, 0));
    tbl.push_back(v(1, 1, 0, 0, 1, 0, 2'b00, 0, 0, 0));
    tbl.push_back(v(1, 1, 0, 0, 1, 1, 2'b10, 0, 1, 1));
    // Burst hold: four acked beats for p0 while p1 waits.
    tbl.push_back(v(0, 0, 1, 0, 0, 0, 2'b00, 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 1, 1, 0, 2'b00, 0, 0, 0));
    for (int i = 0; i < 4; i++) tbl.push_back(v(0, 1, 0, 1, 1, 1, 2'b01, 1, 0, 1));
    tbl.push_back(v(0, 1, 0, 0, 1, 0, 2'b01, 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 1, 0, 2'b00, 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 1, 0, 2'b10, 0, 0, 1));
    // Reset while in GRANT1: transfer abandoned, acks blocked, next tie to p0.
    tbl.push_back(v(0, 0, 1, 0, 0, 0, 2'b00, 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 1, 0, 2'b00, 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 1, 0, 2'b10, 0, 0, 1));
    tbl.push_back(v(0, 1, 1, 0, 1, 1, 2'b10, 0, 1, 1));
    tbl.push_back(v(0, 1, 0, 0, 0, 1, 2'b00, 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 1, 1, 0, 2'b00, 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 1, 1, 1, 2'b01, 1, 0, 1));

    repeat (2) @(posedge clk);
    #1;
    foreach (tbl[i]) begin
      rst = tbl[i].rst; p0_req = tbl[i].r0; p1_req = tbl[i].r1; s_ack = tbl[i].ack;
      @(negedge clk);
      if (tbl[i].chk) begin
        check($sformatf("row%0d", i), tbl[i].dut ? obs_b : obs_a, expect_obs(tbl[i]));
      end
      @(posedge clk);
      #1;
    end

    // Watchdog: p0 granted, secondary silent. Cycle n counts from the first
    // granted stb cycle; the hit lands after 8 un-acked cycles (n=8) with stb
    // forced low and read data 0, then again at n=17 where a real ack wins.
    rst = 1'b1; p0_req = 1'b0; p1_req = 1'b0; s_ack = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0; p0_req = 1'b1;
    @(posedge clk);
    #1;
    for (int n = 0; n < 18; n++) begin
      logic        hit, tmo;
      logic [31:0] rd;
      s_ack = (n == 17);
      hit   = (n == 8) || (n == 17);
      tmo   = (n == 8);
      rd    = tmo ? 32'h0 : SEC_RD;
      @(negedge clk);
      check($sformatf("wdog%0d", n),
            OBS_W'({a_grant, a_s.cyc, a_s.stb, a_p0.ack, a_p1.ack, a_tmo, a_p0.dat_r}),
            OBS_W'({2'b01, 1'b1, ~hit, hit, 1'b0, tmo, rd}));
      @(posedge clk);
      #1;
    end
    p0_req = 1'b0; s_ack = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
